// File: rtl/victim_wb_pkg.sv
// Shared types and defaults for the victim-cache write-back drain engine.
// Optional feature macro: VICTIM_WB_FWD_EN (forwarding lookup of pending lines).
package victim_wb_pkg;

  localparam int WB_TAG_WIDTH   = 32;
  localparam int WB_DATA_WIDTH  = 128;
  localparam int WB_BEAT_WIDTH  = 32;
  localparam int WB_DEPTH       = 4;
  localparam int BEATS_PER_LINE = WB_DATA_WIDTH / WB_BEAT_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } wb_state_t;

  // One buffered victim line at the default geometry.
  typedef struct packed {
    logic [WB_TAG_WIDTH-1:0]  tag;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/victim_wb_queue.sv
// Circular buffer of displaced lines with optional forwarding compare.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   enq_valid/enq_ready      enqueue handshake (ready = count < DEPTH)
//   enq_tag, enq_data        line being enqueued
//   pop                      retire the head entry
//   head_tag, head_data      oldest entry
//   count                    number of occupied entries
//   lookup_tag/hit/data      forwarding lookup (active with VICTIM_WB_FWD_EN)
module victim_wb_queue
  import victim_wb_pkg::*;
#(
  parameter int TAG_WIDTH  = WB_TAG_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int DEPTH      = WB_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  logic [TAG_WIDTH-1:0]  enq_tag,
  input  logic [DATA_WIDTH-1:0] enq_data,
  input  logic                  pop,
  output logic [TAG_WIDTH-1:0]  head_tag,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [CW-1:0]         count,
  input  logic [TAG_WIDTH-1:0]  lookup_tag,
  output logic                  lookup_hit,
  output logic [DATA_WIDTH-1:0] lookup_data
);

  logic [DEPTH-1:0][TAG_WIDTH-1:0]  tag_mem;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_mem;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          enq;

  assign enq_ready = (count < CW'(DEPTH));
  assign enq       = enq_valid && enq_ready;
  assign head_tag  = tag_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Line storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (rst && enq) begin
      tag_mem[wr_ptr]  <= enq_tag;
      data_mem[wr_ptr] <= enq_data;
    end
  end

`ifdef VICTIM_WB_FWD_EN
  // Walk oldest to newest so a later (newer) match overrides an older one.
  always_comb begin
    logic [PW-1:0] idx;
    lookup_hit  = 1'b0;
    lookup_data = '0;
    idx         = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if ((CW'(k) < count) && (tag_mem[idx] == lookup_tag)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_mem[idx];
      end
    end
  end
`else
  logic unused_lookup;
  assign unused_lookup = ^lookup_tag;
  assign lookup_hit    = 1'b0;
  assign lookup_data   = '0;
`endif

endmodule

// File: rtl/victim_wb_drain.sv
// Write-back drain engine: buffers displaced victim lines and writes each to
// memory as one address phase followed by BEATS narrow data beats, oldest first.
// Optional feature macro: VICTIM_WB_FWD_EN (lookup of pending lines).
// Ports:
//   clk, rst                         clock, synchronous active-low reset
//   evict_valid/ready/tag/data       line intake from the victim cache
//   mem_wr_req/addr/ack              address phase
//   mem_wr_data/data_valid/ready/last data beats
//   wb_busy                          lines pending or transfer in flight
//   lookup_tag/hit/data              forwarding lookup for dcache misses
module victim_wb_drain
  import victim_wb_pkg::*;
#(
  parameter int TAG_WIDTH  = WB_TAG_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int BEAT_WIDTH = WB_BEAT_WIDTH,
  parameter int DEPTH      = WB_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  evict_valid,
  output logic                  evict_ready,
  input  logic [TAG_WIDTH-1:0]  evict_tag,
  input  logic [DATA_WIDTH-1:0] evict_data,
  output logic                  mem_wr_req,
  output logic [TAG_WIDTH-1:0]  mem_wr_addr,
  input  logic                  mem_wr_ack,
  output logic [BEAT_WIDTH-1:0] mem_wr_data,
  output logic                  mem_wr_data_valid,
  input  logic                  mem_wr_data_ready,
  output logic                  mem_wr_last,
  output logic                  wb_busy,
  input  logic [TAG_WIDTH-1:0]  lookup_tag,
  output logic                  lookup_hit,
  output logic [DATA_WIDTH-1:0] lookup_data
);

  localparam int BEATS = DATA_WIDTH / BEAT_WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  wb_state_t state, state_n;
  logic [BW-1:0] beat, beat_n;
  logic [CW-1:0] count, cnt_after;
  logic [TAG_WIDTH-1:0]  head_tag;
  logic [DATA_WIDTH-1:0] head_data;
  logic [BEATS-1:0][BEAT_WIDTH-1:0] head_beats;
  logic last_beat, pop, enq_fire;

  victim_wb_queue #(
    .TAG_WIDTH (TAG_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .enq_valid  (evict_valid),
    .enq_ready  (evict_ready),
    .enq_tag    (evict_tag),
    .enq_data   (evict_data),
    .pop        (pop),
    .head_tag   (head_tag),
    .head_data  (head_data),
    .count      (count),
    .lookup_tag (lookup_tag),
    .lookup_hit (lookup_hit),
    .lookup_data(lookup_data)
  );

  assign head_beats = head_data;
  assign last_beat  = (beat == BW'(BEATS - 1));
  assign pop        = (state == DATA) && mem_wr_data_ready && last_beat;
  assign enq_fire   = evict_valid && evict_ready;
  // Occupancy after this cycle's pop, counting a same-cycle enqueue.
  assign cnt_after  = count - CW'(1) + CW'(enq_fire);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_n;
      beat  <= beat_n;
    end
  end

  always_comb begin
    state_n = state;
    beat_n  = beat;
    case (state)
      IDLE: if (count != '0) state_n = ADDR;
      ADDR: if (mem_wr_ack) begin
        state_n = DATA;
        beat_n  = '0;
      end
      DATA: if (mem_wr_data_ready) begin
        if (last_beat) begin
          beat_n  = '0;
          state_n = (cnt_after != '0) ? ADDR : IDLE;
        end else begin
          beat_n = beat + BW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Moore outputs; address and data are gated so idle outputs read as zero.
  assign mem_wr_req        = (state == ADDR);
  assign mem_wr_addr       = (state == ADDR) ? head_tag : '0;
  assign mem_wr_data_valid = (state == DATA);
  assign mem_wr_data       = (state == DATA) ? head_beats[beat] : '0;
  assign mem_wr_last       = (state == DATA) && last_beat;
  assign wb_busy           = (count != '0) || (state != IDLE);

endmodule

// File: doc/victim_wb_drain.md
# victim_wb_drain

Write-back drain engine on the memory side of the victim cache in the write-back dcache. When the victim cache overwrites an entry, it hands the displaced line (tag + data) to this block. The block buffers up to DEPTH lines and writes each line to main memory as one address phase followed by a burst of narrow data beats, oldest line first.

## Interface
- TAG_WIDTH, 32, line address sent to memory
- DATA_WIDTH, 128, line width
- BEAT_WIDTH, 32, memory data-bus width; DATA_WIDTH must be an integer multiple of it
- DEPTH, 4, buffer entries; power of two, ≥2
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- evict_valid  in  1  victim cache offers a displaced line
- evict_ready  out  1  buffer can accept; high exactly when count < DEPTH
- evict_tag  in  TAG_WIDTH  line address of the offered line
- evict_data  in  DATA_WIDTH  line data of the offered line
- mem_wr_req  out  1  address phase valid
- mem_wr_addr  out  TAG_WIDTH  tag of the head entry
- mem_wr_ack  in  1  memory accepts the address phase
- mem_wr_data  out  BEAT_WIDTH  current beat
- mem_wr_data_valid  out  1  beat valid
- mem_wr_data_ready  in  1  memory accepts the beat
- mem_wr_last  out  1  current beat is the final beat of the line
- wb_busy  out  1  count ≠ 0 or FSM ≠ IDLE
- lookup_tag  in  TAG_WIDTH  dcache miss tag to check against pending lines
- lookup_hit  out  1  a pending line matches lookup_tag
- lookup_data  out  DATA_WIDTH  data of the matching line

## Operation
- Enqueue: when evict_valid && evict_ready, write {tag, data} at wr_ptr, then wr_ptr++ (mod DEPTH) and count++.
- evict_ready depends only on count, never on the same-cycle dequeue. A full buffer stalls the victim cache.
- FSM states IDLE, ADDR, DATA. Outputs are Moore-decoded from state and beat counter.
- IDLE: if count ≠ 0, go to ADDR.
- ADDR: mem_wr_req=1, mem_wr_addr=head tag. Hold both stable until mem_wr_ack. On ack, go to DATA with beat=0.
- DATA: mem_wr_data_valid=1. mem_wr_data = head_data[beat*BEAT_WIDTH +: BEAT_WIDTH], lowest slice first. mem_wr_last=1 when beat = BEATS-1.
- On mem_wr_data_ready, beat++.
- On the last beat handshake: pop the head (rd_ptr++, count--). Go to ADDR if count after the pop is nonzero, else go to IDLE.
- Simultaneous enqueue and pop: count is unchanged and both pointers advance.
- Duplicate tags are accepted. Each is written back separately, in order.
- Beat counter width is clog2(BEATS); it wraps to 0 on the pop.

## Timing
- Reset (rst=0 at a clk edge) sets:
  - pointers, count, and beat to 0; state to IDLE
  - every output to 0, except evict_ready=1 and lookup_data=0
- Stored data is not cleared on reset.
- Reset asserted mid-burst abandons the line immediately. Memory sees mem_wr_req and mem_wr_data_valid drop the next cycle.
- Enqueue handshake in cycle N with an empty buffer: count=1 in N+1, mem_wr_req=1 in N+2.
- With zero-wait memory, one line occupies 1 ADDR cycle plus BEATS DATA cycles. Back-to-back lines have no IDLE gap.
- mem_wr_req and mem_wr_data_valid never drop without their handshake, except on reset.

## Configuration
- VICTIM_WB_FWD_EN defined:
  - lookup_tag is compared combinationally against every valid entry, including the head during its burst.
  - On multiple matches, the newest entry wins.
  - A line enqueued in cycle N becomes visible in N+1.
  - A popped line stops matching in the cycle after its last beat.
- VICTIM_WB_FWD_EN undefined: ports stay present, lookup_hit=0, lookup_data=0, no compare logic.

## Structure
- Package victim_wb_pkg holds:
  - typedef wb_state_t (IDLE, ADDR, DATA)
  - struct wb_entry_t {tag, data}
  - localparam BEATS_PER_LINE = DATA_WIDTH/BEAT_WIDTH
- Sub-module victim_wb_queue holds the circular buffer, pointers, count, and the forwarding compare.
- The top level holds the FSM and the beat mux.

## Test plan
- Single line: enqueue tag 0x1000, data 0x44443333_22221111_0000FFFF_DEADBEEF; memory always ready.
  - mem_wr_req in N+2 with addr 0x1000.
  - Beats DEADBEEF, 0000FFFF, 22221111, 44443333, with last on the 4th beat.
  - wb_busy low afterwards.
- Fill: 5 evict attempts back-to-back with mem_wr_ack held 0.
  - evict_ready drops after the 4th enqueue; the 5th is held until the first pop.
- Backpressure: toggle mem_wr_data_ready 1,0,1,0 during a burst.
  - Beat values hold while ready=0.
  - Exactly 4 beats transfer; addr stays stable during the ack wait.
- Simultaneous: enqueue in the same cycle as a last-beat pop while count=2.
  - count stays 2 and line order is preserved.
- Reset mid-DATA after beat 1: all outputs 0 next cycle, buffer empty, then a fresh line drains normally.
- VICTIM_WB_FWD_EN: enqueue tag 0x20 twice with data A then B; lookup 0x20 → hit=1, data B.
  - After both pops → hit=0.
  - Macro off → hit=0 always.
